// File: rtl/obstacle_spawner_if.sv
// Handshake bundle between the obstacle spawner and its driver: control/random
// inputs toward the spawner, obstacle field and status back out.
interface obstacle_spawner_if #(
  parameter int X_W   = 10,
  parameter int SLOTS = 4
);
  logic [4:0]           rnd;
  logic                 tick;
  logic                 start;
  logic                 halt;
  logic [1:0]           state;
  logic [SLOTS-1:0]     active;
  logic [SLOTS*X_W-1:0] obs_x;
  logic [SLOTS*2-1:0]   obs_type;
  logic                 spawn;

  modport master (
    output rnd, tick, start, halt,
    input  state, active, obs_x, obs_type, spawn
  );

  modport slave (
    input  rnd, tick, start, halt,
    output state, active, obs_x, obs_type, spawn
  );
endinterface

// File: rtl/obstacle_spawner.sv
// Scrolling obstacle field for the dinosaur game: moves obstacles left on each
// frame tick and spawns new ones from the LFSR word after randomised gaps.
module obstacle_spawner #(
  parameter int SCREEN_W = 640,
  parameter int X_W      = 10,
  parameter int SLOTS    = 4,
  parameter int SPEED    = 2,
  parameter int MIN_GAP  = 32
) (
  input logic               clk,
  input logic               RESET,
  obstacle_spawner_if.slave bus
);

  localparam int GAP_W = 7;
  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  localparam logic [X_W-1:0]   SPAWN_X = X_W'(SCREEN_W - 1);
  localparam logic [X_W-1:0]   STEP    = X_W'(SPEED);
  localparam logic [GAP_W-1:0] GAP_MIN = GAP_W'(MIN_GAP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SLOTS-1:0]   active_q, active_d;
  logic [X_W-1:0]     x_q    [SLOTS];
  logic [X_W-1:0]     x_d    [SLOTS];
  logic [1:0]         type_q [SLOTS];
  logic [1:0]         type_d [SLOTS];
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               spawn_q, spawn_d;

  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               do_tick;

  logic [SLOTS*X_W-1:0] obs_x_pk;
  logic [SLOTS*2-1:0]   obs_type_pk;

  assign do_tick = (state_q == S_RUN) && bus.tick && !bus.halt;

  // Lowest-index free slot, judged on the pre-tick active vector.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (bus.halt)  state_d = S_HALT;
      S_HALT:  if (bus.start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    active_d = active_q;
    x_d      = x_q;
    type_d   = type_q;
    gap_d    = gap_q;
    spawn_d  = 1'b0;

    if (state_q == S_IDLE && bus.start) gap_d = GAP_MIN;
    if (state_q == S_HALT && bus.start) active_d = '0;

    if (do_tick) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (active_q[i]) begin
          if (x_q[i] >= STEP) x_d[i] = x_q[i] - STEP;
          else                active_d[i] = 1'b0;
        end
      end

      // A full field keeps gap at 0, so the spawn is retried on later ticks.
      if (gap_q != '0) begin
        gap_d = gap_q - 1'b1;
      end else if (free_found) begin
        active_d[free_idx] = 1'b1;
        x_d[free_idx]      = SPAWN_X;
        type_d[free_idx]   = bus.rnd[1:0];
        gap_d              = GAP_MIN + GAP_W'({bus.rnd[4:2], 3'b000});
        spawn_d            = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      active_q <= '0;
      gap_q    <= '0;
      spawn_q  <= 1'b0;
      // NOTE: the slot arrays are reset too, since obs_x/obs_type must read 0
      // after reset rather than stale positions.
      for (int i = 0; i < SLOTS; i++) begin
        x_q[i]    <= '0;
        type_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      active_q <= active_d;
      gap_q    <= gap_d;
      spawn_q  <= spawn_d;
      x_q      <= x_d;
      type_q   <= type_d;
    end
  end

  always_comb begin
    obs_x_pk    = '0;
    obs_type_pk = '0;
    for (int i = 0; i < SLOTS; i++) begin
      obs_x_pk[i*X_W +: X_W]  = x_q[i];
      obs_type_pk[2*i +: 2]   = type_q[i];
    end
  end

  assign bus.state    = state_q;
  assign bus.active   = active_q;
  assign bus.obs_x    = obs_x_pk;
  assign bus.obs_type = obs_type_pk;
  assign bus.spawn    = spawn_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: vector table, directed corner sequences and a
// randomised run, all checked against a slot-list reference model.
module tb_obstacle_spawner;

  localparam int SCREEN_W = 640;
  localparam int X_W      = 10;
  localparam int SLOTS    = 4;
  localparam int SPEED    = 2;
  localparam int MIN_GAP  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obstacle_spawner_if #(.X_W(X_W), .SLOTS(SLOTS)) bus ();

  obstacle_spawner #(
    .SCREEN_W(SCREEN_W), .X_W(X_W), .SLOTS(SLOTS), .SPEED(SPEED), .MIN_GAP(MIN_GAP)
  ) dut (
    .clk   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a list of slots with integer positions.
  int m_state;
  bit m_act [SLOTS];
  int m_x   [SLOTS];
  int m_typ [SLOTS];
  int m_gap;
  bit m_spawn;

  task automatic model_edge(input bit rn, input bit st, input bit tk, input bit hl,
                            input logic [4:0] r);
    int free;
    m_spawn = 1'b0;
    if (!rn) begin
      m_state = 0;
      m_gap   = 0;
      for (int i = 0; i < SLOTS; i++) begin
        m_act[i] = 1'b0; m_x[i] = 0; m_typ[i] = 0;
      end
      return;
    end
    case (m_state)
      0: if (st) begin m_state = 1; m_gap = MIN_GAP; end
      1: begin
        if (hl) m_state = 2;
        else if (tk) begin
          free = -1;
          for (int i = 0; i < SLOTS; i++)
            if (!m_act[i] && free < 0) free = i;
          for (int i = 0; i < SLOTS; i++) begin
            if (m_act[i]) begin
              if (m_x[i] < SPEED) m_act[i] = 1'b0;
              else                m_x[i]   = m_x[i] - SPEED;
            end
          end
          if (m_gap > 0) m_gap = m_gap - 1;
          else if (free >= 0) begin
            m_act[free] = 1'b1;
            m_x[free]   = SCREEN_W - 1;
            m_typ[free] = int'(r) % 4;
            m_gap       = MIN_GAP + (int'(r) / 4) * 8;
            m_spawn     = 1'b1;
          end
        end
      end
      default: if (st) begin
        m_state = 0;
        for (int i = 0; i < SLOTS; i++) m_act[i] = 1'b0;
      end
    endcase
  endtask

  function automatic logic [SLOTS-1:0] m_act_pk();
    logic [SLOTS-1:0] v;
    for (int i = 0; i < SLOTS; i++) v[i] = m_act[i];
    return v;
  endfunction

  function automatic logic [SLOTS*X_W-1:0] m_x_pk();
    logic [SLOTS*X_W-1:0] v;
    for (int i = 0; i < SLOTS; i++) v[i*X_W +: X_W] = X_W'(m_x[i]);
    return v;
  endfunction

  function automatic logic [SLOTS*2-1:0] m_typ_pk();
    logic [SLOTS*2-1:0] v;
    for (int i = 0; i < SLOTS; i++) v[2*i +: 2] = 2'(m_typ[i]);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " state"},    64'(bus.state),    64'(m_state));
    check({tag, " active"},   64'(bus.active),   64'(m_act_pk()));
    check({tag, " obs_x"},    64'(bus.obs_x),    64'(m_x_pk()));
    check({tag, " obs_type"}, 64'(bus.obs_type), 64'(m_typ_pk()));
    check({tag, " spawn"},    64'(bus.spawn),    64'(m_spawn));
  endtask

  // One clock: drive on the falling edge, update the model on the rising
  // edge, leave the caller 1 time unit after it to sample.
  task automatic apply(input bit rn, input bit st, input bit tk, input bit hl,
                       input logic [4:0] r);
    @(negedge clk);
    rst_n     = rn;
    bus.start = st;
    bus.tick  = tk;
    bus.halt  = hl;
    bus.rnd   = r;
    @(posedge clk);
    model_edge(rn, st, tk, hl, r);
    #1;
  endtask

  function automatic logic [X_W-1:0] slot_x(input int i);
    logic [SLOTS*X_W-1:0] v;
    v = bus.obs_x;
    return v[i*X_W +: X_W];
  endfunction

  typedef struct {
    bit         rn, st, tk, hl;
    logic [4:0] r;
    logic [1:0] e_state;
    logic [3:0] e_act;
    bit         e_spawn;
  } vec_t;

  vec_t vecs [11];
  logic [SLOTS*X_W-1:0] frozen_x;
  bit exp_sp;

  initial begin
    bus.start = 1'b0; bus.tick = 1'b0; bus.halt = 1'b0; bus.rnd = '0;

    // Reset and FSM transitions: {rn, st, tk, hl, rnd, state, active, spawn}
    vecs[0]  = '{0, 1, 1, 0, 5'd0, 2'd0, 4'h0, 0};
    vecs[1]  = '{0, 0, 1, 1, 5'd0, 2'd0, 4'h0, 0};
    vecs[2]  = '{1, 0, 1, 0, 5'd0, 2'd0, 4'h0, 0};
    vecs[3]  = '{1, 0, 0, 1, 5'd0, 2'd0, 4'h0, 0};
    vecs[4]  = '{1, 1, 0, 0, 5'd0, 2'd1, 4'h0, 0};
    vecs[5]  = '{1, 0, 1, 0, 5'd0, 2'd1, 4'h0, 0};
    vecs[6]  = '{1, 1, 1, 1, 5'd0, 2'd2, 4'h0, 0};
    vecs[7]  = '{1, 0, 1, 0, 5'd0, 2'd2, 4'h0, 0};
    vecs[8]  = '{1, 1, 0, 0, 5'd0, 2'd0, 4'h0, 0};
    vecs[9]  = '{1, 1, 0, 0, 5'd0, 2'd1, 4'h0, 0};
    vecs[10] = '{0, 0, 1, 0, 5'd0, 2'd0, 4'h0, 0};
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].rn, vecs[i].st, vecs[i].tk, vecs[i].hl, vecs[i].r);
      check($sformatf("vec%0d state", i),  64'(bus.state),  64'(vecs[i].e_state));
      check($sformatf("vec%0d active", i), 64'(bus.active), 64'(vecs[i].e_act));
      check($sformatf("vec%0d spawn", i),  64'(bus.spawn),  64'(vecs[i].e_spawn));
    end

    // First spawn with rnd=10110, then rnd=0: slot0 scrolls off, field fills.
    apply(0, 0, 0, 0, 5'd0);
    apply(1, 1, 0, 0, 5'd0);
    for (int t = 1; t <= 360; t++) begin
      apply(1, 0, 1, 0, (t == 33) ? 5'b10110 : 5'd0);
      compare_all($sformatf("seqA t%0d", t));
      exp_sp = (t == 33) || (t == 106) || (t == 139) || (t == 172) || (t == 354);
      check($sformatf("seqA spawn t%0d", t), 64'(bus.spawn), 64'(exp_sp));
      for (int i = 0; i < SLOTS; i++)
        if (bus.active[i]) check("seqA nowrap", 64'(slot_x(i) > X_W'(SCREEN_W - 1)), 64'(0));
      if (t == 33) begin
        check("seqA first active", 64'(bus.active), 64'(4'b0001));
        check("seqA first x",      64'(slot_x(0)),  64'(639));
        check("seqA first type",   64'(bus.obs_type[1:0]), 64'(2));
      end
      if (t == 352) check("seqA slot0 x=1", 64'(slot_x(0)), 64'(1));
      if (t == 353) check("seqA slot0 gone", 64'(bus.active[0]), 64'(0));
    end

    // Slot exhaustion with rnd held at 0.
    apply(0, 0, 0, 0, 5'd0);
    apply(1, 1, 0, 0, 5'd0);
    for (int t = 1; t <= 360; t++) begin
      apply(1, 0, 1, 0, 5'd0);
      compare_all($sformatf("seqB t%0d", t));
      exp_sp = (t == 33) || (t == 66) || (t == 99) || (t == 132) || (t == 354);
      check($sformatf("seqB spawn t%0d", t), 64'(bus.spawn), 64'(exp_sp));
      if (t == 132) check("seqB full", 64'(bus.active), 64'(4'b1111));
      if (t == 353) check("seqB freed", 64'(bus.active), 64'(4'b1110));
      if (t == 354) begin
        check("seqB refill active", 64'(bus.active), 64'(4'b1111));
        check("seqB refill x",      64'(slot_x(0)),  64'(639));
      end
    end

    // Freeze in HALT, then clear and restart.
    apply(1, 0, 0, 1, 5'd0);
    check("halt state", 64'(bus.state), 64'(2));
    frozen_x = m_x_pk();
    for (int k = 0; k < 10; k++) begin
      apply(1, 0, 1, 0, 5'($urandom));
      check($sformatf("frozen x k%0d", k), 64'(bus.obs_x), 64'(frozen_x));
      check("frozen state", 64'(bus.state), 64'(2));
    end
    apply(1, 1, 0, 0, 5'd0);
    check("halt->idle state",  64'(bus.state),  64'(0));
    check("halt->idle active", 64'(bus.active), 64'(0));
    apply(1, 1, 0, 0, 5'd0);
    check("idle->run state", 64'(bus.state), 64'(1));
    apply(1, 1, 1, 1, 5'd0);
    check("halt beats start", 64'(bus.state), 64'(2));
    compare_all("halt+start");

    // Reset mid-run with active=0111 and a tick in the same cycle.
    apply(0, 0, 0, 0, 5'd0);
    apply(1, 1, 0, 0, 5'd0);
    for (int t = 1; t <= 99; t++) apply(1, 0, 1, 0, 5'd0);
    check("pre-reset active", 64'(bus.active), 64'(4'b0111));
    apply(0, 0, 1, 0, 5'd0);
    check("midrun rst state",  64'(bus.state),  64'(0));
    check("midrun rst active", 64'(bus.active), 64'(0));
    check("midrun rst spawn",  64'(bus.spawn),  64'(0));
    check("midrun rst obs_x",  64'(bus.obs_x),  64'(0));

    // Randomised run against the model.
    for (int c = 0; c < 4000; c++) begin
      apply($urandom_range(0, 199) != 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) == 0,
            5'($urandom));
      compare_all($sformatf("rand c%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
